ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Background scrubber for a memory array of 15-bit BCH(15,10) codewords, with 10 data bits and 5 parity bits at [14:10].
- Walks addresses 0..DEPTH-1 and reads each word.
- Single-bit errors: writes back the corrected, re-encoded codeword.
- Double-bit errors: counts them and records the address; the word is not written back.
- Sits between the system controller and the ECC-protected memory, downstream of the memory read port and upstream of the memory write port.

Parameters:
ADDR_W, 8, memory address width
DEPTH, 256, number of words scrubbed per pass (DEPTH <= 2**ADDR_W)
CNT_W, 16, width of the saturating error counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  pulse; begins a pass when idle, ignored otherwise
abort  input  1  pulse; ends a pass after the current word completes
clr_stats  input  1  pulse; zeroes counters, irq_uncorr and last_uncorr_addr
mem_req  output  1  memory request, held until mem_gnt
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_W  request address
mem_wdata  output  15  write codeword
mem_gnt  input  1  request accepted this cycle
mem_rvalid  input  1  read data valid; arrives >=1 cycle after read grant; one outstanding request
mem_rdata  input  15  read codeword
busy  output  1  pass in progress
done  output  1  one-cycle pulse at pass end (normal or aborted)
aborted  output  1  registered with done; 1 if the pass ended by abort
corr_cnt  output  CNT_W  corrected-word count, saturating
uncorr_cnt  output  CNT_W  uncorrectable-word count, saturating
last_uncorr_addr  output  ADDR_W  address of the most recent uncorrectable word
irq_uncorr  output  1  sticky; set on any uncorrectable word

Behaviour:
- Reset: all outputs 0; FSM in IDLE; address counter 0.
- Encode, with d = data[9:0]:
  - p0 = d0^d1^d2^d4^d5^d8
  - p1 = d1^d2^d3^d5^d6^d9
  - p2 = d0^d1^d3^d5^d6^d7^d8
  - p3 = d1^d2^d4^d6^d7^d8^d9
  - p4 = d0^d1^d3^d4^d7^d9
- Syndrome s[4:0] = encode(rdata[9:0]) ^ rdata[14:10].
- Syndrome to corrected bit:
  - 00001->10, 00010->11, 00100->12, 01000->13, 10000->14
  - 10101->0, 11111->1, 01011->2, 10110->3, 11001->4
  - 00111->5, 01110->6, 11100->7, 01101->8, 11010->9
- Classification:
  - s==0: clean.
  - s in the table: correctable.
  - Any other nonzero s, including even weight and 10011: uncorrectable.
- States:
  - IDLE: busy=0. On start: addr=0, go to RD_REQ. If start and clr_stats arrive together, the clear happens first.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=addr. On mem_gnt go to RD_WAIT.
  - RD_WAIT: on mem_rvalid, register rdata, go to CHECK.
  - CHECK (1 cycle): compute s.
    - Clean: go to NEXT.
    - Correctable: corr_cnt++; mem_wdata = {encode(fixed data), fixed data}; go to WR_REQ.
    - Uncorrectable: uncorr_cnt++, last_uncorr_addr=addr, irq_uncorr=1; go to NEXT.
  - WR_REQ: mem_req=1, mem_we=1, same addr. On mem_gnt go to NEXT.
  - NEXT:
    - If abort is pending: done=1, aborted=1, go to IDLE.
    - Else if addr==DEPTH-1: done=1, aborted=0, go to IDLE.
    - Else: addr++, go to RD_REQ.
- Abort is latched in any non-IDLE state. Outstanding requests are never dropped: mem_req is not deasserted before mem_gnt. The latch clears on entry to IDLE.
- Counters saturate at all-ones. clr_stats has priority over a same-cycle increment. clr_stats is accepted in any state.
- mem_addr and mem_wdata are stable while mem_req is high.
- A mid-pass rst_n assertion immediately drops mem_req and returns all state to reset values.
- Per-word latency with zero-wait memory:
  - Clean or uncorrectable: 5 cycles (RD_REQ, RD_WAIT, CHECK, NEXT, plus the RD_WAIT response cycle).
  - Correctable: 6 cycles.

Decomposition:
- Package ecc_bch15_pkg:
  - Constants DATA_W=10, PAR_W=5, CW_W=15.
  - Functions bch15_encode(data) and bch15_syndrome(cw).
  - FSM state enum.
- Sub-module ecc_bch15_fix: combinational. Takes the codeword; produces the corrected 10-bit data, the correctable flag and the uncorrectable flag.

Test Plan:
- All words 15'h0000 and 15'h33FF (data 3FF), zero-wait memory, DEPTH=4 -> no writes; done after 20 cycles; both counters 0.
- addr2 = 15'h0002 (bit1 flipped) -> write of 15'h0000 to addr2; corr_cnt=1.
- addr1 = 15'h0003 (s=01010) -> no write; uncorr_cnt=1; last_uncorr_addr=1; irq_uncorr=1. addr3 = 15'h0400 (s=00001) -> write of 15'h0000 to addr3.
- Syndrome 10011 injected (cw 15'h4C00) -> classified uncorrectable, no write.
- mem_gnt held low for 7 cycles on a read -> mem_req, mem_addr and mem_we stay stable; abort pulsed during the wait -> current word completes; done=1 and aborted=1; the next address is never requested.
- corr_cnt preloaded to all-ones via repeated errors with CNT_W=2 -> holds at 3. clr_stats with a same-cycle correction -> 0. rst_n low during WR_REQ -> mem_req=0 in the same cycle.

Source files
------------

// File: rtl/ecc_bch15_pkg.sv
// BCH(15,10) code helpers and scrubber state encoding.
// Codeword layout: parity in [14:10], data in [9:0].
package ecc_bch15_pkg;

  localparam int DATA_W = 10;
  localparam int PAR_W  = 5;
  localparam int CW_W   = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR_REQ,
    S_NEXT
  } state_e;

  function automatic logic [PAR_W-1:0] bch15_encode(
    input logic [DATA_W-1:0] d
  );
    logic [PAR_W-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[8];
    p[1] = d[1] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9];
    p[2] = d[0] ^ d[1] ^ d[3] ^ d[5] ^ d[6] ^ d[7]
         ^ d[8];
    p[3] = d[1] ^ d[2] ^ d[4] ^ d[6] ^ d[7] ^ d[8]
         ^ d[9];
    p[4] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[7] ^ d[9];
    return p;
  endfunction

  function automatic logic [PAR_W-1:0] bch15_syndrome(
    input logic [CW_W-1:0] cw
  );
    return bch15_encode(cw[DATA_W-1:0]) ^ cw[CW_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/ecc_bch15_fix.sv
// Single-error corrector for BCH(15,10) codewords.
// Any nonzero syndrome outside the table is uncorrectable.
module ecc_bch15_fix
  import ecc_bch15_pkg::*;
(
  input  logic [CW_W-1:0]   cw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              corr_o,
  output logic              uncorr_o
);

  logic [PAR_W-1:0] syn;
  logic [CW_W-1:0]  flip;

  // Map the syndrome onto the single bit it points at.
  always_comb begin
    syn  = bch15_syndrome(cw_i);
    flip = '0;
    case (syn)
      5'b00001: flip[10] = 1'b1;
      5'b00010: flip[11] = 1'b1;
      5'b00100: flip[12] = 1'b1;
      5'b01000: flip[13] = 1'b1;
      5'b10000: flip[14] = 1'b1;
      5'b10101: flip[0]  = 1'b1;
      5'b11111: flip[1]  = 1'b1;
      5'b01011: flip[2]  = 1'b1;
      5'b10110: flip[3]  = 1'b1;
      5'b11001: flip[4]  = 1'b1;
      5'b00111: flip[5]  = 1'b1;
      5'b01110: flip[6]  = 1'b1;
      5'b11100: flip[7]  = 1'b1;
      5'b01101: flip[8]  = 1'b1;
      5'b11010: flip[9]  = 1'b1;
      default:  flip     = '0;
    endcase
    data_o   = cw_i[DATA_W-1:0] ^ flip[DATA_W-1:0];
    corr_o   = (syn != '0) && (flip != '0);
    uncorr_o = (syn != '0) && (flip == '0);
  end

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: reads every word, rewrites
// single-bit errors, logs uncorrectable ones.
module ecc_scrub_ctrl
  import ecc_bch15_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_stats,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [CW_W-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic [ADDR_W-1:0] last_uncorr_addr,
  output logic              irq_uncorr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR =
    ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [CW_W-1:0]     rdata_q;
  logic [CW_W-1:0]     wdata_q;
  logic                req_q;
  logic                we_q;
  logic                abort_q;
  logic                done_q;
  logic                aborted_q;
  logic [CNT_W-1:0]    corr_q;
  logic [CNT_W-1:0]    uncorr_q;
  logic [ADDR_W-1:0]   last_q;
  logic                irq_q;

  logic [DATA_W-1:0]   fix_data;
  logic                fix_corr;
  logic                fix_uncorr;

  ecc_bch15_fix u_fix (
    .cw_i     (rdata_q),
    .data_o   (fix_data),
    .corr_o   (fix_corr),
    .uncorr_o (fix_uncorr)
  );

  // Scrub sequencer, request outputs and error statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      corr_q    <= '0;
      uncorr_q  <= '0;
      last_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        abort_q <= 1'b1;
      end
      if (clr_stats) begin
        corr_q   <= '0;
        uncorr_q <= '0;
        last_q   <= '0;
        irq_q    <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q  <= '0;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (fix_corr) begin
            if (!clr_stats && corr_q != '1) begin
              corr_q <= corr_q + CNT_W'(1);
            end
            wdata_q <= {bch15_encode(fix_data), fix_data};
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_WR_REQ;
          end else begin
            if (fix_uncorr && !clr_stats) begin
              if (uncorr_q != '1) begin
                uncorr_q <= uncorr_q + CNT_W'(1);
              end
              last_q <= addr_q;
              irq_q  <= 1'b1;
            end
            state_q <= S_NEXT;
          end
        end
        S_WR_REQ: begin
          if (mem_gnt) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (abort_q || abort) begin
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            abort_q   <= 1'b0;
            state_q   <= S_IDLE;
          end else if (addr_q == LAST_ADDR) begin
            done_q    <= 1'b1;
            abort_q   <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            state_q <= S_RD_REQ;
          end
        end
        default: begin
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          abort_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;
  assign done             = done_q;
  assign aborted          = aborted_q;
  assign corr_cnt         = corr_q;
  assign uncorr_cnt       = uncorr_q;
  assign last_uncorr_addr = last_q;
  assign irq_uncorr       = irq_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a 4-word
// memory model: read data returns two edges after grant.
module tb_ecc_scrub_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        clr_stats;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [14:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [14:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [1:0]  corr_cnt;
  logic [1:0]  uncorr_cnt;
  logic [7:0]  last_uncorr_addr;
  logic        irq_uncorr;

  logic        gnt_en;
  logic [14:0] mem [0:3];
  logic        p1;
  logic [7:0]  a1;
  int          wr_cnt;
  int          rd_cnt;

  int checks;
  int errors;

  ecc_scrub_ctrl #(
    .ADDR_W (8),
    .DEPTH  (4),
    .CNT_W  (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .clr_stats        (clr_stats),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .busy             (busy),
    .done             (done),
    .aborted          (aborted),
    .corr_cnt         (corr_cnt),
    .uncorr_cnt       (uncorr_cnt),
    .last_uncorr_addr (last_uncorr_addr),
    .irq_uncorr       (irq_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_gnt = mem_req & gnt_en;

  // Memory model: grant-driven reads and writes.
  always @(posedge clk) begin
    p1         <= mem_req & mem_gnt & ~mem_we;
    a1         <= mem_addr;
    mem_rvalid <= p1;
    mem_rdata  <= mem[a1[1:0]];
    if (mem_req & mem_gnt & ~mem_we) rd_cnt <= rd_cnt + 1;
    if (mem_req & mem_gnt & mem_we) begin
      mem[mem_addr[1:0]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;
  int wr0;
  int rd0;

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    clr_stats = 1'b0;
    gnt_en    = 1'b1;
    p1         <= 1'b0;
    mem_rvalid <= 1'b0;
    wr_cnt     <= 0;
    rd_cnt     <= 0;
    mem[0] <= 15'h0000;
    mem[1] <= 15'h33FF;
    mem[2] <= 15'h0000;
    mem[3] <= 15'h33FF;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_outs", {busy, done, aborted, mem_req,
                     mem_we, irq_uncorr}, 0);
    chk("rst_cnts", {corr_cnt, uncorr_cnt,
                     last_uncorr_addr, mem_addr}, 0);
    rst_n = 1'b1;
    tick();

    // Pass 1: all clean words.
    wr0 = wr_cnt;
    start_pass();
    chk("busy_after_start", busy, 1);
    wait_done(n);
    chk("p1_done", done, 1);
    chk("p1_cycles", n, 20);
    chk("p1_aborted", aborted, 0);
    chk("p1_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("p1_writes", wr_cnt - wr0, 0);
    tick();
    chk("p1_done_pulse", done, 0);
    chk("p1_idle", busy, 0);

    // Pass 2: mixed correctable / uncorrectable.
    mem[0] <= 15'h4C00;
    mem[1] <= 15'h0003;
    mem[2] <= 15'h0002;
    mem[3] <= 15'h0400;
    tick();
    wr0 = wr_cnt;
    start_pass();
    wait_done(n);
    chk("p2_done", done, 1);
    chk("p2_cycles", n, 22);
    chk("p2_corr", corr_cnt, 2);
    chk("p2_uncorr", uncorr_cnt, 2);
    chk("p2_last", last_uncorr_addr, 1);
    chk("p2_irq", irq_uncorr, 1);
    tick();
    chk("p2_writes", wr_cnt - wr0, 2);
    chk("p2_mem0_kept", mem[0], 15'h4C00);
    chk("p2_mem1_kept", mem[1], 15'h0003);
    chk("p2_mem2_fixed", mem[2], 15'h0000);
    chk("p2_mem3_fixed", mem[3], 15'h0000);

    // Clear stats while idle.
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cnts", {corr_cnt, uncorr_cnt}, 0);
    chk("clr_last", last_uncorr_addr, 0);
    chk("clr_irq", irq_uncorr, 0);

    // Stalled read grant with abort pulse.
    mem[0] <= 15'h0000;
    mem[1] <= 15'h0000;
    mem[2] <= 15'h0000;
    mem[3] <= 15'h0000;
    gnt_en = 1'b0;
    tick();
    rd0 = rd_cnt;
    start_pass();
    for (int i = 0; i < 7; i++) begin
      chk("stall_req", {mem_req, mem_we, mem_addr},
          {1'b1, 1'b0, 8'h00});
      abort = (i == 2);
      tick();
    end
    abort  = 1'b0;
    gnt_en = 1'b1;
    wait_done(n);
    chk("ab_done", done, 1);
    chk("ab_aborted", aborted, 1);
    tick();
    chk("ab_idle", busy, 0);
    chk("ab_reads", rd_cnt - rd0, 1);
    chk("ab_req_off", mem_req, 0);

    // Saturation of corr_cnt with four corrections.
    mem[0] <= 15'h0002;
    mem[1] <= 15'h0002;
    mem[2] <= 15'h0002;
    mem[3] <= 15'h0002;
    tick();
    wr0 = wr_cnt;
    start_pass();
    wait_done(n);
    chk("sat_cycles", n, 24);
    chk("sat_corr", corr_cnt, 3);
    tick();
    chk("sat_writes", wr_cnt - wr0, 4);
    chk("sat_mem2", mem[2], 15'h0000);

    // clr_stats in the same cycle as a correction.
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr2_corr", corr_cnt, 0);
    mem[0] <= 15'h0002;
    mem[1] <= 15'h0002;
    mem[2] <= 15'h0002;
    mem[3] <= 15'h0002;
    tick();
    start_pass();
    n = 0;
    while (mem_rvalid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("rvalid_seen", mem_rvalid, 1);
    tick();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_vs_inc", corr_cnt, 0);
    chk("wr_req", {mem_req, mem_we, mem_addr},
        {1'b1, 1'b1, 8'h00});
    chk("wr_data", mem_wdata, 15'h0000);

    // Asynchronous reset while the write is pending.
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", mem_we, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_no_write", wr_cnt - wr0, 0);
    chk("rst_mem0", mem[0], 15'h0002);
    chk("rst_state", {busy, done, mem_req, corr_cnt}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
